// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 active-low matrix keypad scan.
// Queued key codes are pressed one at a time for HOLD_CYCLES, then released
// for GAP_CYCLES; while pressed, the key's row is pulled low whenever the
// decoder strobes its column.
// Optional contact chatter at press/release edges: define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 1_000_000,
  parameter int unsigned GAP_CYCLES    = 1_000_000,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned BOUNCE_CYCLES = 50_000,
  parameter int unsigned BOUNCE_PERIOD = 5_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    key_in,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic [3:0]                    col,
  output logic [3:0]                    row,
  output logic                          key_active,
  output logic [3:0]                    active_code,
  output logic                          press_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  // Reject parameter sets the timing scheme cannot honour
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 || BOUNCE_PERIOD < 1 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("keypad_emulator: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                key_active_q;
  logic [3:0]          code_q;
  logic                press_done_q;
  logic                busy_q;
  logic                key_ready_q;
  logic [3:0]          row_q;

  logic [3:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [FCNT_W-1:0]   count_q;
  logic [FCNT_W-1:0]   count_d;
  logic                push_c;
  logic                pop_c;
  logic                press_c;
  logic [1:0]          kr_c;
  logic [1:0]          kc_c;

  assign push_c = key_valid && key_ready_q;
  assign pop_c  = (state_q == IDLE) && (count_q != '0);

  // Queue occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Key-code storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= key_in;
    end
  end

  // Queue pointers, occupancy and ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_ready_q <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      key_ready_q <= (count_d < FCNT_W'(FIFO_DEPTH));
    end
  end

  // Press sequencer: pop -> hold -> release gap -> idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_active_q <= 1'b0;
      code_q       <= 4'h0;
      press_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      press_done_q <= 1'b0;
      busy_q       <= 1'b1;
      case (state_q)
        IDLE: begin
          busy_q <= (count_d != '0);
          if (pop_c) begin
            state_q      <= HOLD;
            cnt_q        <= CNT_W'(HOLD_CYCLES - 1);
            code_q       <= mem_q[rd_ptr_q];
            key_active_q <= 1'b1;
            press_done_q <= (HOLD_CYCLES == 1);
            busy_q       <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q      <= GAP;
            cnt_q        <= CNT_W'(GAP_CYCLES - 1);
            key_active_q <= 1'b0;
          end else begin
            cnt_q        <= cnt_q - CNT_W'(1);
            press_done_q <= (cnt_q == CNT_W'(1));
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= (count_d != '0);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          key_active_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int unsigned BPER_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_WIN = CNT_W'(HOLD_CYCLES - BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_WIN  = CNT_W'(GAP_CYCLES - BOUNCE_CYCLES);
  localparam logic [BPER_W-1:0] BPER_RELOAD = BPER_W'(BOUNCE_PERIOD - 1);

  logic              press_q;
  logic [BPER_W-1:0] bper_q;

  // Chattering contact: toggles every BOUNCE_PERIOD inside the edge windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= 1'b0;
      bper_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          press_q <= pop_c;
          bper_q  <= BPER_RELOAD;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            press_q <= 1'b0;
            bper_q  <= BPER_RELOAD;
          end else if (cnt_q > HOLD_WIN) begin
            if (bper_q == '0) begin
              press_q <= ~press_q;
              bper_q  <= BPER_RELOAD;
            end else begin
              bper_q <= bper_q - BPER_W'(1);
            end
          end else begin
            press_q <= 1'b1;
          end
        end
        GAP: begin
          if (cnt_q > GAP_WIN) begin
            if (bper_q == '0) begin
              press_q <= ~press_q;
              bper_q  <= BPER_RELOAD;
            end else begin
              bper_q <= bper_q - BPER_W'(1);
            end
          end else begin
            press_q <= 1'b0;
          end
        end
        default: press_q <= 1'b0;
      endcase
    end
  end

  assign press_c = press_q;
`else
  assign press_c = key_active_q;
`endif

  // Fixed key map: code -> (row index, column index)
  always_comb begin
    kr_c = 2'd0;
    kc_c = 2'd0;
    case (code_q)
      4'h1: begin kr_c = 2'd3; kc_c = 2'd3; end
      4'h2: begin kr_c = 2'd3; kc_c = 2'd2; end
      4'h3: begin kr_c = 2'd3; kc_c = 2'd1; end
      4'hA: begin kr_c = 2'd3; kc_c = 2'd0; end
      4'h4: begin kr_c = 2'd2; kc_c = 2'd3; end
      4'h5: begin kr_c = 2'd2; kc_c = 2'd2; end
      4'h6: begin kr_c = 2'd2; kc_c = 2'd1; end
      4'hB: begin kr_c = 2'd2; kc_c = 2'd0; end
      4'h7: begin kr_c = 2'd1; kc_c = 2'd3; end
      4'h8: begin kr_c = 2'd1; kc_c = 2'd2; end
      4'h9: begin kr_c = 2'd1; kc_c = 2'd1; end
      4'hC: begin kr_c = 2'd1; kc_c = 2'd0; end
      4'h0: begin kr_c = 2'd0; kc_c = 2'd3; end
      4'hF: begin kr_c = 2'd0; kc_c = 2'd2; end
      4'hE: begin kr_c = 2'd0; kc_c = 2'd1; end
      default: begin kr_c = 2'd0; kc_c = 2'd0; end
    endcase
  end

  // Row return: pull the key's row low while its column is strobed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 4'hF;
    end else if (press_c && !col[kc_c]) begin
      row_q <= ~(4'b0001 << kr_c);
    end else begin
      row_q <= 4'hF;
    end
  end

  assign key_ready   = key_ready_q;
  assign row         = row_q;
  assign key_active  = key_active_q;
  assign active_code = code_q;
  assign press_done  = press_done_q;
  assign fifo_count  = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed vectors plus randomized traffic,
// all outputs compared every cycle against a timeline-based reference model.
module tb_keypad_emulator;

  localparam int unsigned H  = 8;
  localparam int unsigned G  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned B  = 2;
  localparam int unsigned P  = 1;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    key_in;
  logic          key_valid;
  logic          key_ready;
  logic [3:0]    col;
  logic [3:0]    row;
  logic          key_active;
  logic [3:0]    active_code;
  logic          press_done;
  logic [CW-1:0] fifo_count;
  logic          busy;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D),
    .BOUNCE_CYCLES(B), .BOUNCE_PERIOD(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .col(col), .row(row), .key_active(key_active),
    .active_code(active_code), .press_done(press_done),
    .fifo_count(fifo_count), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: queue of codes and the start cycle of the current key
  logic [3:0]    mq [$];
  bit            have_cur;
  int unsigned   cur_start;
  int unsigned   cyc = 0;
  logic [3:0]    m_code;
  bit            m_press;
  logic [3:0]    exp_row, exp_code;
  logic [CW-1:0] exp_count;
  bit            exp_active, exp_done, exp_ready, exp_busy;

  // Keypad face read left-to-right, top-to-bottom: row 3 at top, col 3 at left
  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  typedef struct {
    logic [3:0] code;
    logic [3:0] colv;
    logic [3:0] rowv;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic key_pos(input logic [3:0] code, output int r, output int c);
    r = 0;
    c = 0;
    for (int p = 0; p < 16; p++) begin
      if (layout[p] == code) begin
        r = 3 - p / 4;
        c = 3 - p % 4;
      end
    end
  endtask

  function automatic bit hold_press(input int unsigned e);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (e < B) return ((e / P) % 2) == 0;
`endif
    return (e < H);
  endfunction

  function automatic bit gap_press(input int unsigned e);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (e < B) return ((e / P) % 2) == 1;
`endif
    return (e > G);
  endfunction

  task automatic model_reset();
    mq.delete();
    have_cur   = 1'b0;
    cur_start  = 0;
    m_code     = 4'h0;
    m_press    = 1'b0;
    exp_row    = 4'hF;
    exp_code   = 4'h0;
    exp_count  = '0;
    exp_active = 1'b0;
    exp_done   = 1'b0;
    exp_ready  = 1'b1;
    exp_busy   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held for it
  task automatic model_step();
    bit idle_prev, full_prev, do_pop;
    int unsigned e;
    int r, c;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    key_pos(m_code, r, c);
    exp_row = (m_press && col[c] == 1'b0) ? ~(4'b0001 << r) : 4'hF;
    idle_prev = !have_cur;
    full_prev = (mq.size() >= D);
    do_pop    = idle_prev && (mq.size() > 0);
    if (do_pop) begin
      m_code    = mq.pop_front();
      have_cur  = 1'b1;
      cur_start = cyc;
    end
    if (key_valid && !full_prev) mq.push_back(key_in);
    if (have_cur && cyc >= cur_start + H + G) have_cur = 1'b0;
    e = cyc - cur_start;
    exp_active = have_cur && (e < H);
    exp_done   = have_cur && (e == H - 1);
    m_press    = have_cur && ((e < H) ? hold_press(e) : gap_press(e - H));
    exp_code   = m_code;
    exp_count  = CW'(mq.size());
    exp_ready  = (mq.size() < D);
    exp_busy   = have_cur || (mq.size() > 0);
  endtask

  task automatic check_all();
    chk("row", 32'(row), 32'(exp_row));
    chk("key_active", 32'(key_active), 32'(exp_active));
    chk("active_code", 32'(active_code), 32'(exp_code));
    chk("press_done", 32'(press_done), 32'(exp_done));
    chk("fifo_count", 32'(fifo_count), 32'(exp_count));
    chk("key_ready", 32'(key_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  // One clock: edge, model update, then compare on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_active();
    for (int i = 0; i < 40 && !key_active; i++) cycle();
    chk("wait_active", 32'(key_active), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) cycle();
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic push(input logic [3:0] code);
    key_valid = 1'b1;
    key_in    = code;
    cycle();
    key_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned row_from, gap_from, first_rise;
    int unsigned rise_cyc [$];
    logic [3:0]  rise_code [$];
    logic [3:0]  exp_order [5];
    logic        prev_act;

`ifdef KEYPAD_EMU_BOUNCE_EN
    row_from = 4;
    gap_from = 12;
`else
    row_from = 2;
    gap_from = 10;
`endif

    vecs[0]  = '{4'hD, 4'hE, 4'hE};
    vecs[1]  = '{4'hD, 4'h7, 4'hF};
    vecs[2]  = '{4'hD, 4'h6, 4'hE};
    vecs[3]  = '{4'h5, 4'hB, 4'hB};
    vecs[4]  = '{4'h1, 4'h7, 4'h7};
    vecs[5]  = '{4'hA, 4'h7, 4'hF};
    vecs[6]  = '{4'hA, 4'hE, 4'h7};
    vecs[7]  = '{4'h0, 4'h7, 4'hE};
    vecs[8]  = '{4'h9, 4'hD, 4'hD};
    vecs[9]  = '{4'hC, 4'h0, 4'hD};
    vecs[10] = '{4'hF, 4'hB, 4'hE};
    vecs[11] = '{4'h8, 4'hF, 4'hF};

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = 4'h0;
    col       = 4'hF;
    model_reset();
    repeat (2) cycle();
    chk("reset_row", 32'(row), 32'hF);
    chk("reset_ready", 32'(key_ready), 32'd1);
    rst_n = 1'b1;
    cycle();

    // Column scan with nothing pressed keeps rows idle
    for (int i = 0; i < 4; i++) begin
      col = ~(4'b0001 << i);
      cycle();
      chk("idle_scan_row", 32'(row), 32'hF);
      chk("idle_scan_busy", 32'(busy), 32'd0);
      chk("idle_scan_count", 32'(fifo_count), 32'd0);
    end

    // Single key 0x5: exact hold/gap timing
    col = 4'hB;
    push(4'h5);
    chk("t_active_after_push", 32'(key_active), 32'd0);
    chk("t_busy_after_push", 32'(busy), 32'd1);
    for (int unsigned k = 1; k <= H + G + 1; k++) begin
      cycle();
      if (k <= H) begin
        chk("t_hold_active", 32'(key_active), 32'd1);
        chk("t_hold_done", 32'(press_done), 32'(k == H));
        if (k >= row_from) chk("t_hold_row", 32'(row), 32'hB);
      end else if (k <= H + G) begin
        chk("t_gap_active", 32'(key_active), 32'd0);
        if (k >= gap_from) chk("t_gap_row", 32'(row), 32'hF);
      end else begin
        chk("t_idle_busy", 32'(busy), 32'd0);
        chk("t_idle_code", 32'(active_code), 32'h5);
      end
    end

    // Table of (code, column strobe, expected row)
    foreach (vecs[i]) begin
      col = 4'hF;
      push(vecs[i].code);
      wait_active();
      col = vecs[i].colv;
      repeat (4) cycle();
      chk("tbl_row", 32'(row), 32'(vecs[i].rowv));
      col = 4'hF;
      wait_idle();
    end

    // Queue fills while key 0 is held: B rejected, order and spacing kept
    push(4'h0);
    wait_active();
    first_rise = cyc;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'hA);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(key_ready), 32'd0);
    push(4'hB);
    chk("full_count_after_reject", 32'(fifo_count), 32'd4);
    rise_cyc.push_back(first_rise);
    rise_code.push_back(active_code);
    prev_act = key_active;
    for (int i = 0; i < 200 && busy; i++) begin
      cycle();
      if (key_active && !prev_act) begin
        rise_cyc.push_back(cyc);
        rise_code.push_back(active_code);
      end
      prev_act = key_active;
    end
    chk("fifo_busy_falls", 32'(busy), 32'd0);
    chk("fifo_num_presses", 32'(rise_cyc.size()), 32'd5);
    exp_order = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hA};
    for (int i = 0; i < 5 && i < rise_code.size(); i++) begin
      chk("fifo_order", 32'(rise_code[i]), 32'(exp_order[i]));
      if (i > 0) chk("fifo_spacing", rise_cyc[i] - rise_cyc[i-1], 32'(H + G + 1));
    end

    // Asynchronous reset in the middle of a hold with keys queued
    col = 4'h7;
    push(4'h7);
    wait_active();
    push(4'h9);
    push(4'hE);
    repeat (2) cycle();
    chk("pre_reset_row", 32'(row), 32'hD);
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_row", 32'(row), 32'hF);
    chk("async_rst_active", 32'(key_active), 32'd0);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_active", 32'(key_active), 32'd0);

    // Randomized traffic: heavy pushes, then sparse pushes
    for (int i = 0; i < 1600; i++) begin
      key_valid = (($urandom % 100) < ((i < 800) ? 30 : 4));
      key_in    = 4'($urandom);
      col       = 4'($urandom);
      cycle();
    end
    key_valid = 1'b0;
    col       = 4'hF;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
